// File: rtl/serial_adder_sub.sv
// serial_adder_sub: bit-serial WIDTH-bit adder/subtractor with start/busy/done handshake.
module serial_adder_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [CW-1:0] cnt;
  logic c, s, c_nxt, last;
  assign s = a_sr[0] ^ b_sr[0] ^ c;
  assign c_nxt = (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0]));
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nxt;
  always_comb
    state_nxt = (state == IDLE && start) ? RUN :
                (state == RUN && last)   ? DONE :
                (state == DONE)          ? IDLE : state;
  // ovf compares the carry into the MSB (c) with the carry out of it (c_nxt) on the last bit
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      cnt  <= '0;
      c    <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sr <= a;
      b_sr <= sub ? ~b : b;
      c    <= sub | cin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= {s, r_sr[WIDTH-1:1]};
      c    <= c_nxt;
      cnt  <= cnt + CW'(1);
      if (last) begin
        sum  <= {s, r_sr[WIDTH-1:1]};
        cout <= c_nxt;
        ovf  <= c ^ c_nxt;
      end
    end
  end
endmodule
